// File: rtl/buffer_arbiter.sv
// Round-robin arbiter granting three requesters (rx FIFO, tx FIFO, compute) burst access
// to a single-port unified buffer; one word per cycle, all outputs registered.
//   state   | meaning
//   IDLE    | waiting for any req; arbitrate and latch the winner's burst
//   BURST   | one buffer access per cycle at the latched address/direction
//   DONE    | one-cycle done pulse to the winner, pointer advances
module buffer_arbiter #(
  parameter int ADDRESS_SIZE = 9,
  parameter int BUFFER_SIZE  = 512,
  parameter int MAX_BURST    = 8,
  parameter int LEN_WIDTH    = $clog2(MAX_BURST) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                req,
  input  logic [2:0]                req_we,
  input  logic [3*ADDRESS_SIZE-1:0] req_addr,
  input  logic [3*LEN_WIDTH-1:0]    req_len,
  output logic [2:0]                gnt,
  output logic [2:0]                done,
  output logic                      buf_en,
  output logic                      buf_we,
  output logic [ADDRESS_SIZE-1:0]   buf_addr,
  output logic                      busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [1:0]              p_q, p_d;
  logic [1:0]              win_q, win_d;
  logic [2:0]              gnt_q, gnt_d;
  logic [2:0]              done_q, done_d;
  logic                    buf_en_q, buf_en_d;
  logic                    buf_we_q, buf_we_d;
  logic [ADDRESS_SIZE-1:0] buf_addr_q, buf_addr_d;
  logic                    busy_q, busy_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;

  logic [2:0]              rot;
  logic [1:0]              off;
  logic [2:0]              sum;
  logic [1:0]              win;
  logic                    sel_we;
  logic [ADDRESS_SIZE-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]    sel_len;
  logic [LEN_WIDTH-1:0]    len_eff;

  // Rotate req so bit 0 is the requester at pointer p, then take the first set bit.
  always_comb begin
    case (p_q)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else             off = 2'd2;
    sum = {1'b0, p_q} + {1'b0, off};
    win = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];

    sel_we   = 1'b0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < 3; i++) begin
      if (win == 2'(i)) begin
        sel_we   = req_we[i];
        sel_addr = req_addr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
        sel_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end

    if (sel_len == '0)                            len_eff = LEN_WIDTH'(1);
    else if (sel_len > LEN_WIDTH'(MAX_BURST))     len_eff = LEN_WIDTH'(MAX_BURST);
    else                                          len_eff = sel_len;
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    done_d     = 3'b000;
    buf_en_d   = buf_en_q;
    buf_we_d   = buf_we_q;
    buf_addr_d = buf_addr_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    len_d      = len_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d    = S_BURST;
          win_d      = win;
          gnt_d      = 3'b001 << win;
          buf_en_d   = 1'b1;
          buf_we_d   = sel_we;
          buf_addr_d = sel_addr;
          len_d      = len_eff;
          cnt_d      = '0;
          busy_d     = 1'b1;
        end
      end
      S_BURST: begin
        if (cnt_q == len_q - LEN_WIDTH'(1)) begin
          state_d  = S_DONE;
          gnt_d    = 3'b000;
          buf_en_d = 1'b0;
          done_d   = gnt_q;
          p_d      = (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
        end else begin
          cnt_d      = cnt_q + LEN_WIDTH'(1);
          buf_addr_d = (buf_addr_q == ADDRESS_SIZE'(BUFFER_SIZE - 1)) ? '0
                                                                      : buf_addr_q + ADDRESS_SIZE'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      p_q        <= 2'd0;
      win_q      <= 2'd0;
      gnt_q      <= 3'b000;
      done_q     <= 3'b000;
      buf_en_q   <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      buf_en_q   <= buf_en_d;
      buf_we_q   <= buf_we_d;
      buf_addr_q <= buf_addr_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign buf_en   = buf_en_q;
  assign buf_we   = buf_we_q;
  assign buf_addr = buf_addr_q;
  assign busy     = busy_q;

endmodule

// File: doc/buffer_arbiter.md
BUFFER_ARBITER -- requirements
Module: buffer_arbiter

Interface
REQ-001 Parameter ADDRESS_SIZE, default 9, is the unified buffer address width.
REQ-002 Parameter BUFFER_SIZE, default 512, is the buffer depth in words and sets the address wrap point.
REQ-003 Parameter MAX_BURST, default 8, is the maximum words per grant.
REQ-004 Parameter LEN_WIDTH, default $clog2(MAX_BURST)+1, is the burst-length field width.
REQ-005 clk  input  1  system clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req  input  3  per-requester access request: bit0 rx FIFO, bit1 tx FIFO, bit2 compute.
REQ-008 req_we  input  3  per-requester direction: 1 write, 0 read.
REQ-009 req_addr  input  3*ADDRESS_SIZE  per-requester start address; slice i belongs to requester i.
REQ-010 req_len  input  3*LEN_WIDTH  per-requester burst length in words; slice i belongs to requester i.
REQ-011 gnt  output  3  one-hot grant, held for the whole burst.
REQ-012 done  output  3  one-cycle completion pulse to the granted requester.
REQ-013 buf_en  output  1  buffer access strobe, one word per cycle.
REQ-014 buf_we  output  1  buffer write enable; 0 means read.
REQ-015 buf_addr  output  ADDRESS_SIZE  buffer word address.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, BURST, DONE. All outputs SHALL be registered.
REQ-018 IDLE: if any req bit is high, the block SHALL select a winner by round-robin, scanning from pointer p in order p, p+1, p+2 (mod 3).
REQ-019 On that same edge it SHALL latch the winner's req_we, req_addr and req_len, set gnt to the winner's one-hot value, and enter BURST.
REQ-020 IDLE with req=0 SHALL stay in IDLE with gnt=0, buf_en=0 and done=0.
REQ-021 BURST: buf_en=1, buf_we equals the latched direction, and buf_addr equals the current address.
REQ-022 In BURST the address SHALL increment by 1 per cycle and wrap from BUFFER_SIZE-1 to 0.
REQ-023 A word counter SHALL increment each BURST cycle; when it reaches latched_len-1, the next state SHALL be DONE.
REQ-024 A req_len of 0 SHALL be treated as 1.
REQ-025 A req_len greater than MAX_BURST SHALL be clamped to MAX_BURST.
REQ-026 DONE: buf_en=0, gnt=0, done equals the winner's one-hot value for exactly one cycle, p is set to winner+1 (mod 3), and the next state is IDLE.
REQ-027 Timing: the first buffer access occurs 1 cycle after req is sampled in IDLE; done asserts len cycles after the first access; bus occupancy per grant is len+2 cycles.
REQ-028 Inputs SHALL be ignored outside IDLE: deasserting req, or changing addr/len/we, mid-burst does not abort or alter the burst.
REQ-029 All three requesters requesting simultaneously SHALL be served in the order p, p+1, p+2, each with exactly one grant.
REQ-030 A requester that holds req through its own DONE cycle SHALL be re-arbitrated in the following IDLE under the updated p.
REQ-031 gnt SHALL never have more than one bit set, and buf_en SHALL never assert while gnt=0.

Reset
REQ-032 While rst=1 at a clock edge: state=IDLE, p=0, gnt=0, done=0, buf_en=0, buf_we=0, buf_addr=0, busy=0, counter=0.
REQ-033 rst asserted mid-burst SHALL abort the burst on that edge with no done pulse; the next grant follows the reset values (p=0).

Verification
REQ-034 Single request: req=001, we=1, addr=10, len=3 -> buf_en high for 3 cycles at addresses 10, 11, 12 with buf_we=1; done=001 on the following cycle; busy spans 4 cycles.
REQ-035 Wrap-around: req=100, we=0, addr=510, len=4 -> buf_addr 510, 511, 0, 1; buf_we=0.
REQ-036 Contention after reset: req=111 held, len=1 for all -> grants in order 001, 010, 100, then 001 again; each done is a single cycle.
REQ-037 Length edges: len=0 -> exactly 1 access; len=15 with MAX_BURST=8 -> exactly 8 accesses.
REQ-038 Mid-burst disturbance: req dropped and addr changed during a len=5 burst -> all 5 accesses still occur at the original addresses; then assert rst at the 3rd access -> all outputs 0 on the next cycle, no done, and the next grant goes to requester 0 when req=111.
